// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the single-port RAM arbiter and neighbouring memory blocks.
package mem_port_arbiter_pkg;

    localparam int unsigned MEM_ADDR_W = 8;
    localparam int unsigned MEM_DATA_W = 32;

    localparam logic [1:0] OWN_NONE = 2'd0;
    localparam logic [1:0] OWN_I    = 2'd1;
    localparam logic [1:0] OWN_D    = 2'd2;

endpackage

// File: rtl/mem_port_arbiter_starve_counter.sv
// Saturating up-counter with synchronous zero and asynchronous clear.
module mem_port_arbiter_starve_counter #(
    parameter int unsigned   W       = 4,
    parameter logic [W-1:0]  MAX_VAL = '1
) (
    input  logic         clock,
    input  logic         clear,
    input  logic         zero,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            count <= '0;
        end else if (zero) begin
            count <= '0;
        end else if (inc && (count != MAX_VAL)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-port (fetch/data) arbiter onto one synchronous single-port RAM.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W   = MEM_ADDR_W,
    parameter int unsigned DATA_W   = MEM_DATA_W,
    parameter int unsigned MAX_WAIT = 3,
    parameter int unsigned PERF_W   = 16
) (
    input  logic              clock,
    input  logic              clear,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_gnt,
    output logic              i_rvalid,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    output logic              mem_wren,
    input  logic [DATA_W-1:0] mem_dout,
    output logic [PERF_W-1:0] perf_conflicts
);

    localparam int unsigned STARVE_W = 4;

    logic [STARVE_W-1:0] starveCnt;
    logic                starveFull;
    logic                iWait;
    logic [1:0]          owner;
    logic [1:0]          ownerNext;
    logic [DATA_W-1:0]   iHold;
    logic [DATA_W-1:0]   dHold;

    // Data wins conflicts until fetch has been denied MAX_WAIT cycles in a row.
    always_comb begin
        starveFull = (starveCnt == STARVE_W'(MAX_WAIT));
        i_gnt      = !clear && i_req && (!d_req || starveFull);
        d_gnt      = !clear && d_req && !(i_req && starveFull);
        iWait      = i_req && !i_gnt;
    end

    always_comb begin
        mem_addr = d_gnt ? d_addr : i_addr;
        mem_din  = d_gnt ? d_wdata : '0;
        mem_wren = d_gnt && d_we;
    end

    mem_port_arbiter_starve_counter #(
        .W       (STARVE_W),
        .MAX_VAL (STARVE_W'(MAX_WAIT))
    ) u_starve (
        .clock (clock),
        .clear (clear),
        .zero  (!iWait),
        .inc   (iWait),
        .count (starveCnt)
    );

    mem_port_arbiter_starve_counter #(
        .W       (PERF_W),
        .MAX_VAL ('1)
    ) u_perf (
        .clock (clock),
        .clear (clear),
        .zero  (1'b0),
        .inc   (i_req && d_req),
        .count (perf_conflicts)
    );

    // Hold registers keep the last response visible while the pipeline stalls.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            owner <= OWN_NONE;
            iHold <= '0;
            dHold <= '0;
        end else begin
            owner <= ownerNext;
            if (owner == OWN_I) iHold <= mem_dout;
            if (owner == OWN_D) dHold <= mem_dout;
        end
    end

    always_comb begin
        ownerNext = OWN_NONE;
        if (i_gnt) begin
            ownerNext = OWN_I;
        end else if (d_gnt && !d_we) begin
            ownerNext = OWN_D;
        end
    end

    always_comb begin
        i_rvalid = (owner == OWN_I);
        d_rvalid = (owner == OWN_D);
        i_rdata  = i_rvalid ? mem_dout : iHold;
        d_rdata  = d_rvalid ? mem_dout : dHold;
    end

endmodule
